// File: rtl/spi_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// spi_rr_arbiter_if
// Bundles the requester handshake and the spi_top bus that the round-robin
// arbiter sits between.
//   slave  : arbiter view (takes requests and spi_top results, drives grants,
//            responses and spi_top commands)
//   master : environment view (requesters plus spi_top)
// Signals:
//   req/req_data          requester levels and flattened words (slice i)
//   gnt/ack/err           one-hot owner, completion pulse, timeout pulse
//   rsp_data              word read back, valid with ack
//   busy                  arbiter not idle
//   spi_newd/spi_din      command strobe and word to spi_top
//   spi_done/spi_dout     completion strobe and word from spi_top
// ----------------------------------------------------------------------------
interface spi_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 12
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    err;
    logic [DW-1:0]      rsp_data;
    logic               busy;
    logic               spi_newd;
    logic [DW-1:0]      spi_din;
    logic               spi_done;
    logic [DW-1:0]      spi_dout;

    modport slave (
        input  req, req_data, spi_done, spi_dout,
        output gnt, ack, err, rsp_data, busy, spi_newd, spi_din
    );

    modport master (
        output req, req_data, spi_done, spi_dout,
        input  gnt, ack, err, rsp_data, busy, spi_newd, spi_din
    );
endinterface

// File: rtl/spi_rr_arbiter.sv
// ----------------------------------------------------------------------------
// spi_rr_arbiter
// Round-robin scheduler sharing one spi_top master among NREQ requesters.
// The winner's word is latched onto spi_din, spi_newd is held for
// NEWD_CYCLES clocks so the slow sclk domain can sample it, then the arbiter
// waits for spi_done and returns spi_dout to the winner with a one-cycle ack.
// A watchdog aborts with a one-cycle err if done never arrives.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : spi_rr_arbiter_if.slave (requests, grants, responses, spi_top bus)
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module spi_rr_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 12,
    parameter int NEWD_CYCLES = 20,
    parameter int TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             rst,
    spi_rr_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int NW = $clog2(NEWD_CYCLES + 1);

    localparam logic [NW-1:0] NEWD_LAST = NW'(NEWD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [PW-1:0]   ptr_q,    ptr_d;
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] ack_q,    ack_d;
    logic [NREQ-1:0] err_q,    err_d;
    logic [DW-1:0]   rsp_q,    rsp_d;
    logic            busy_q,   busy_d;
    logic            newd_q,   newd_d;
    logic [DW-1:0]   din_q,    din_d;
    logic [DW-1:0]   capt_q,   capt_d;
    logic [CW-1:0]   cyc_q,    cyc_d;
    logic [NW-1:0]   ncnt_q,   ncnt_d;

    // Per-requester word view of the flattened request bus.
    logic [DW-1:0] req_word [NREQ];
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_word
            assign req_word[gi] = bus.req_data[gi*DW +: DW];
        end
    endgenerate

    // Rotating priority search: first set request strictly after ptr_q,
    // wrapping, so the last winner ends up with the lowest priority.
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic            win_found;
    always_comb begin
        int idx;
        idx        = 0;
        win_idx    = ptr_q;
        win_found  = 1'b0;
        win_onehot = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
        win_onehot[win_idx] = win_found;
    end

    logic timeout_hit;
    assign timeout_hit = (cyc_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = '0;
        rsp_d   = rsp_q;
        busy_d  = busy_q;
        newd_d  = newd_q;
        din_d   = din_q;
        capt_d  = capt_q;
        cyc_d   = cyc_q;
        ncnt_d  = ncnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d   = win_onehot;
                    din_d   = req_word[win_idx];
                    newd_d  = 1'b1;
                    busy_d  = 1'b1;
                    ptr_d   = win_idx;
                    cyc_d   = '0;
                    ncnt_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                cyc_d = cyc_q + CW'(1);
                if (state_q == ST_ISSUE) begin
                    ncnt_d = ncnt_q + NW'(1);
                end
                // done beats a simultaneous timeout; either beats the
                // normal end of the newd window.
                if (bus.spi_done) begin
                    capt_d  = bus.spi_dout;
                    newd_d  = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    newd_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (state_q == ST_ISSUE && ncnt_q == NEWD_LAST) begin
                    newd_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                ack_d   = gnt_q;
                rsp_d   = capt_q;
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rsp_q   <= '0;
            busy_q  <= 1'b0;
            newd_q  <= 1'b0;
            din_q   <= '0;
            capt_q  <= '0;
            cyc_q   <= '0;
            ncnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            busy_q  <= busy_d;
            newd_q  <= newd_d;
            din_q   <= din_d;
            capt_q  <= capt_d;
            cyc_q   <= cyc_d;
            ncnt_q  <= ncnt_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rsp_data = rsp_q;
    assign bus.busy     = busy_q;
    assign bus.spi_newd = newd_q;
    assign bus.spi_din  = din_q;

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_rr_arbiter
// Directed bench for spi_rr_arbiter (NREQ=4, DW=12, NEWD_CYCLES=20,
// TIMEOUT=64). The bench plays both the requesters and spi_top; spi_top is
// modelled as a loopback that pulses done once newd has dropped.
// ----------------------------------------------------------------------------
module tb_spi_rr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 12;
    localparam int NEWD = 20;
    localparam int TMO  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    spi_rr_arbiter #(
        .NREQ(NREQ), .DW(DW), .NEWD_CYCLES(NEWD), .TIMEOUT(TMO)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [11:0] w0, input logic [11:0] w1,
                             input logic [11:0] w2, input logic [11:0] w3);
        bus.req_data = {w3, w2, w1, w0};
    endtask

    task automatic apply_reset(input logic [3:0] req_val);
        rst_n   = 1'b0;
        bus.req = req_val;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for a grant, let newd finish, loop the word back with done,
    // then check the ack pulse and returned word.
    task automatic serve(input string tag, input logic [3:0] exp_gnt, input logic [11:0] exp_rsp);
        int k;
        k = 0;
        while (bus.gnt == '0 && k < 100) begin
            tick();
            k++;
        end
        check({tag, " gnt"}, bus.gnt, exp_gnt);
        k = 0;
        while (bus.spi_newd && k < 100) begin
            tick();
            k++;
        end
        bus.spi_dout = bus.spi_din;
        bus.spi_done = 1'b1;
        tick();
        bus.spi_done = 1'b0;
        tick();
        check({tag, " ack"}, bus.ack, exp_gnt);
        check({tag, " rsp"}, bus.rsp_data, exp_rsp);
        $display("txn %s: gnt=%b ack=%b rsp=0x%h", tag, exp_gnt, bus.ack, bus.rsp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int cnt;
        logic seen;

        bus.req      = '0;
        bus.req_data = '0;
        bus.spi_done = 1'b0;
        bus.spi_dout = '0;

        // ---------------- reset state ----------------
        tick();
        check("rst ctl", {bus.gnt, bus.ack, bus.err, bus.busy, bus.spi_newd}, 32'h0);
        check("rst din", bus.spi_din, 32'h0);
        check("rst rsp", bus.rsp_data, 32'h0);
        rst_n = 1'b1;

        // ---------------- 1: single requester ----------------
        set_words(12'hA5C, 12'h000, 12'h000, 12'h000);
        bus.req = 4'b0001;
        tick();
        check("t1 gnt", bus.gnt, 32'h1);
        check("t1 din", bus.spi_din, 32'hA5C);
        check("t1 newd", bus.spi_newd, 32'h1);
        check("t1 busy", bus.busy, 32'h1);
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!bus.spi_newd) break;
            cnt++;
        end
        check("t1 newd_len", cnt, NEWD);
        bus.spi_dout = bus.spi_din;
        bus.spi_done = 1'b1;
        tick();
        bus.spi_done = 1'b0;
        check("t1 resp ack", bus.ack, 32'h0);
        tick();
        check("t1 ack", bus.ack, 32'h1);
        check("t1 rsp", bus.rsp_data, 32'hA5C);
        check("t1 busy_end", bus.busy, 32'h0);
        check("t1 gnt_end", bus.gnt, 32'h0);
        bus.req = '0;
        tick();
        check("t1 ack_pulse", bus.ack, 32'h0);
        $display("txn t1: gnt=0001 rsp=0x%h", bus.rsp_data);

        // ---------------- 2: simultaneous requests ----------------
        set_words(12'h111, 12'h222, 12'h333, 12'h444);
        apply_reset(4'b1111);
        serve("t2 #0", 4'b0001, 12'h111);
        serve("t2 #1", 4'b0010, 12'h222);
        serve("t2 #2", 4'b0100, 12'h333);
        serve("t2 #3", 4'b1000, 12'h444);
        serve("t2 #4", 4'b0001, 12'h111);
        bus.req = '0;
        tick();
        check("t2 idle gnt", bus.gnt, 32'h0);

        // ---------------- 3: fairness ----------------
        apply_reset(4'b0101);
        serve("t3 #0", 4'b0001, 12'h111);
        bus.req = 4'b1101;
        serve("t3 #1", 4'b0100, 12'h333);
        serve("t3 #2", 4'b1000, 12'h444);
        serve("t3 #3", 4'b0001, 12'h111);
        serve("t3 #4", 4'b0100, 12'h333);
        bus.req = '0;
        tick();

        // ---------------- 4: timeout ----------------
        set_words(12'h1E1, 12'h2D2, 12'h3C3, 12'h4B4);
        bus.req = 4'b0010;
        tick();
        check("t4 gnt", bus.gnt, 32'h2);
        cnt  = 0;
        seen = 1'b0;
        while (bus.err == '0 && cnt < 200) begin
            tick();
            cnt++;
            if (cnt == 10) bus.req = 4'b0110;
            if (bus.ack != '0) seen = 1'b1;
        end
        check("t4 err_lat", cnt, TMO);
        check("t4 err", bus.err, 32'h2);
        check("t4 gnt_clr", bus.gnt, 32'h0);
        check("t4 no_ack", seen, 32'h0);
        check("t4 rsp_hold", bus.rsp_data, 32'h333);
        check("t4 busy", bus.busy, 32'h0);
        $display("txn t4: err=%b after %0d cycles", bus.err, cnt);
        bus.req = 4'b0100;
        tick();
        check("t4 err_pulse", bus.err, 32'h0);
        serve("t4 pend", 4'b0100, 12'h3C3);
        bus.req = '0;
        tick();

        // ---------------- 5: reset mid-WAIT ----------------
        bus.req = 4'b1000;
        tick();
        check("t5 gnt", bus.gnt, 32'h8);
        cnt = 0;
        while (bus.spi_newd && cnt < 100) begin
            tick();
            cnt++;
        end
        tick();
        tick();
        check("t5 in_wait", bus.busy, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5 async ctl", {bus.gnt, bus.ack, bus.err, bus.busy, bus.spi_newd}, 32'h0);
        check("t5 async din", bus.spi_din, 32'h0);
        check("t5 async rsp", bus.rsp_data, 32'h0);
        bus.req = 4'b1001;
        tick();
        rst_n = 1'b1;
        tick();
        check("t5 first gnt", bus.gnt, 32'h1);
        serve("t5 first", 4'b0001, 12'h1E1);
        bus.req = 4'b1000;
        serve("t5 second", 4'b1000, 12'h4B4);
        bus.req = '0;
        tick();

        // ---------------- 6a: early done ----------------
        bus.req = 4'b0100;
        tick();
        check("t6a gnt", bus.gnt, 32'h4);
        repeat (4) tick();
        check("t6a newd c5", bus.spi_newd, 32'h1);
        bus.spi_dout = 12'h5A5;
        bus.spi_done = 1'b1;
        tick();
        bus.spi_done = 1'b0;
        check("t6a newd_drop", bus.spi_newd, 32'h0);
        check("t6a ack_wait", bus.ack, 32'h0);
        tick();
        check("t6a ack", bus.ack, 32'h4);
        check("t6a rsp", bus.rsp_data, 32'h5A5);
        $display("txn t6a: ack=%b rsp=0x%h", bus.ack, bus.rsp_data);
        bus.req = '0;
        tick();

        // ---------------- 6b: done on the timeout edge ----------------
        bus.req = 4'b0010;
        tick();
        check("t6b gnt", bus.gnt, 32'h2);
        seen = 1'b0;
        repeat (TMO - 1) begin
            tick();
            if (bus.err != '0) seen = 1'b1;
        end
        bus.spi_dout = 12'h6B6;
        bus.spi_done = 1'b1;
        tick();
        bus.spi_done = 1'b0;
        check("t6b no_err_early", seen, 32'h0);
        check("t6b err_edge", bus.err, 32'h0);
        tick();
        check("t6b ack", bus.ack, 32'h2);
        check("t6b err", bus.err, 32'h0);
        check("t6b rsp", bus.rsp_data, 32'h6B6);
        $display("txn t6b: ack=%b err=%b rsp=0x%h", bus.ack, bus.err, bus.rsp_data);
        bus.req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
